// File: rtl/control_subcmd_fillarea_args_pkg.sv
// rtl/control_subcmd_fillarea_args_pkg.sv - shared types, sizing helpers and defaults for the fillarea argument collector
package control_subcmd_fillarea_args_pkg;

  localparam int DEF_BYTES_PER_PIXEL = 2;
  localparam int DEF_PIXEL_WIDTH     = 64;
  localparam int DEF_PIXEL_HEIGHT    = 32;

  function automatic int num_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Address fields can hold the panel dimension itself, so an out-of-range origin stays detectable.
  function automatic int num_column_address_bits(input int pixel_width);
    return num_bits(pixel_width + 1);
  endfunction

  function automatic int num_row_address_bits(input int pixel_height);
    return num_bits(pixel_height + 1);
  endfunction

  function automatic int arg_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

  localparam int DEF_XW = num_column_address_bits(DEF_PIXEL_WIDTH);
  localparam int DEF_YW = num_row_address_bits(DEF_PIXEL_HEIGHT);
  localparam int X_ARG_BYTES = (DEF_XW + 7) / 8;
  localparam int Y_ARG_BYTES = (DEF_YW + 7) / 8;
  localparam int DEF_TIMEOUT_CYCLES = DEF_PIXEL_WIDTH * DEF_PIXEL_HEIGHT * DEF_BYTES_PER_PIXEL + 16;

  typedef enum logic [3:0] {
    IDLE, ARG_X1, ARG_Y1, ARG_W, ARG_H, ARG_COLOR, CHECK, RUN, DRAIN, ACK, FINISH
  } fillarea_args_fsm_t;

endpackage

// File: rtl/control_subcmd_fillarea_args_if.sv
// rtl/control_subcmd_fillarea_args_if.sv - level handshake between the argument collector and the fillarea writer
interface control_subcmd_fillarea_args_if
  import control_subcmd_fillarea_args_pkg::*;
#(
  parameter int XW = DEF_XW,
  parameter int YW = DEF_YW,
  parameter int CW = DEF_BYTES_PER_PIXEL * 8
) ();
  logic [XW-1:0] x1;
  logic [YW-1:0] y1;
  logic [XW-1:0] width;
  logic [YW-1:0] height;
  logic [CW-1:0] color;
  logic          sub_enable;
  logic          sub_ack;
  logic          sub_reset;
  logic          sub_done;

  modport master (
    output x1, y1, width, height, color, sub_enable, sub_ack, sub_reset,
    input  sub_done
  );

  modport slave (
    input  x1, y1, width, height, color, sub_enable, sub_ack, sub_reset,
    output sub_done
  );
endinterface

// File: rtl/control_arg_shifter.sv
// rtl/control_arg_shifter.sv - N-byte MSB-first shift register with byte counter; full flags the completing byte
module control_arg_shifter
  import control_subcmd_fillarea_args_pkg::*;
#(
  parameter int N_BYTES = 1,
  parameter int OUT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [7:0]       data_in,
  output logic [OUT_W-1:0] value,
  output logic             full
);
  localparam int CNT_W = num_bits(N_BYTES);

  logic [CNT_W-1:0] cnt;

  assign full = shift_en && (cnt == CNT_W'(N_BYTES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           cnt <= '0;
    else if (clear || full) cnt <= '0;
    else if (shift_en)      cnt <= cnt + 1'b1;
  end

  // Bits shifted past OUT_W fall off the top, discarding oversized argument bytes.
  generate
    if (OUT_W > 8) begin : g_wide
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      value <= '0;
        else if (shift_en) value <= {value[OUT_W-9:0], data_in};
      end
    end else begin : g_narrow
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      value <= '0;
        else if (shift_en) value <= data_in[OUT_W-1:0];
      end
    end
  endgenerate
endmodule

// File: rtl/control_subcmd_fillarea.sv
// rtl/control_subcmd_fillarea.sv - fillarea argument collector: byte capture, rectangle check/clamp and writer handshake FSM
module control_subcmd_fillarea_args
  import control_subcmd_fillarea_args_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
  parameter int PIXEL_HEIGHT    = DEF_PIXEL_HEIGHT,
  parameter int PIXEL_WIDTH     = DEF_PIXEL_WIDTH,
  parameter int TIMEOUT_CYCLES  = PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL + 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_start,
  input  logic       abort,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_error,
  control_subcmd_fillarea_args_if.master wr
);
  localparam int XW      = num_column_address_bits(PIXEL_WIDTH);
  localparam int YW      = num_row_address_bits(PIXEL_HEIGHT);
  localparam int CW      = BYTES_PER_PIXEL * 8;
  localparam int X_BYTES = arg_bytes(XW);
  localparam int Y_BYTES = arg_bytes(YW);
  localparam int WD_W    = num_bits(TIMEOUT_CYCLES);
  localparam logic [XW:0] PW = (XW + 1)'(PIXEL_WIDTH);
  localparam logic [YW:0] PH = (YW + 1)'(PIXEL_HEIGHT);

  fillarea_args_fsm_t state, state_nxt;

  logic [XW-1:0] x_arg, w_arg, x1_r, width_r;
  logic [YW-1:0] y_arg, h_arg, y1_r, height_r;
  logic [CW-1:0] c_arg, color_r;
  logic          x_full, y_full, w_full, h_full, c_full;
  logic          take;
  logic [XW:0]   x_end;
  logic [YW:0]   y_end;
  logic          bad_origin, empty_area, run_phase, timeout, kill;
  logic          set_error, load_out;
  logic [WD_W-1:0] wdog;
  logic          drain_cnt, error_r, sub_reset_r;

  assign take = data_valid && !abort;

  control_arg_shifter #(.N_BYTES(X_BYTES), .OUT_W(XW)) u_x1 (
    .clk(clk), .reset_n(reset_n), .clear(state == IDLE), .shift_en(take && state == ARG_X1),
    .data_in(data_in), .value(x_arg), .full(x_full));
  control_arg_shifter #(.N_BYTES(Y_BYTES), .OUT_W(YW)) u_y1 (
    .clk(clk), .reset_n(reset_n), .clear(state == IDLE), .shift_en(take && state == ARG_Y1),
    .data_in(data_in), .value(y_arg), .full(y_full));
  control_arg_shifter #(.N_BYTES(X_BYTES), .OUT_W(XW)) u_w (
    .clk(clk), .reset_n(reset_n), .clear(state == IDLE), .shift_en(take && state == ARG_W),
    .data_in(data_in), .value(w_arg), .full(w_full));
  control_arg_shifter #(.N_BYTES(Y_BYTES), .OUT_W(YW)) u_h (
    .clk(clk), .reset_n(reset_n), .clear(state == IDLE), .shift_en(take && state == ARG_H),
    .data_in(data_in), .value(h_arg), .full(h_full));
  control_arg_shifter #(.N_BYTES(BYTES_PER_PIXEL), .OUT_W(CW)) u_color (
    .clk(clk), .reset_n(reset_n), .clear(state == IDLE), .shift_en(take && state == ARG_COLOR),
    .data_in(data_in), .value(c_arg), .full(c_full));

  // One extra bit keeps the end coordinate from wrapping before it is compared to the panel size.
  assign x_end      = {1'b0, x_arg} + {1'b0, w_arg};
  assign y_end      = {1'b0, y_arg} + {1'b0, h_arg};
  assign bad_origin = ({1'b0, x_arg} >= PW) || ({1'b0, y_arg} >= PH);
  assign empty_area = (w_arg == '0) || (h_arg == '0);
  assign run_phase  = (state == RUN) || (state == DRAIN) || (state == ACK);
  assign timeout    = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign kill       = run_phase && (abort || timeout);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    set_error = 1'b0;
    load_out  = 1'b0;
    case (state)
      IDLE:      if (cmd_start) state_nxt = ARG_X1;
      ARG_X1:    if (abort) state_nxt = IDLE; else if (x_full) state_nxt = ARG_Y1;
      ARG_Y1:    if (abort) state_nxt = IDLE; else if (y_full) state_nxt = ARG_W;
      ARG_W:     if (abort) state_nxt = IDLE; else if (w_full) state_nxt = ARG_H;
      ARG_H:     if (abort) state_nxt = IDLE; else if (h_full) state_nxt = ARG_COLOR;
      ARG_COLOR: if (abort) state_nxt = IDLE; else if (c_full) state_nxt = CHECK;
      CHECK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          load_out = 1'b1;
          if (bad_origin) begin
            set_error = 1'b1;
            state_nxt = FINISH;
          end else if (empty_area) begin
            state_nxt = FINISH;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN:    if (kill) state_nxt = FINISH; else if (wr.sub_done) state_nxt = DRAIN;
      DRAIN:  if (kill) state_nxt = FINISH; else if (drain_cnt) state_nxt = ACK;
      ACK:    if (kill) state_nxt = FINISH; else if (!wr.sub_done) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) set_error = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog        <= '0;
      drain_cnt   <= 1'b0;
      error_r     <= 1'b0;
      sub_reset_r <= 1'b0;
      x1_r        <= '0;
      y1_r        <= '0;
      width_r     <= '0;
      height_r    <= '0;
      color_r     <= '0;
    end else begin
      wdog        <= run_phase ? wdog + 1'b1 : '0;
      drain_cnt   <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      sub_reset_r <= kill;
      if (state == IDLE && cmd_start) error_r <= 1'b0;
      else if (set_error)             error_r <= 1'b1;
      if (load_out) begin
        x1_r     <= x_arg;
        y1_r     <= y_arg;
        width_r  <= (x_end > PW) ? XW'(PW - {1'b0, x_arg}) : w_arg;
        height_r <= (y_end > PH) ? YW'(PH - {1'b0, y_arg}) : h_arg;
        color_r  <= c_arg;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign cmd_done      = (state == FINISH);
  assign cmd_error     = error_r;
  assign wr.sub_enable = (state == RUN) || (state == DRAIN);
  assign wr.sub_ack    = (state == ACK);
  assign wr.sub_reset  = sub_reset_r;
  assign wr.x1         = x1_r;
  assign wr.y1         = y1_r;
  assign wr.width      = width_r;
  assign wr.height     = height_r;
  assign wr.color      = color_r;
endmodule

// File: doc/control_subcmd_fillarea_args.md
Name: control_subcmd_fillarea_args

Overview:
- Upstream stage of the fillarea sub-command writer.
- After the command decoder recognises the fillarea opcode, this block collects the argument bytes from the control byte stream: x1, y1, width, height, then color.
- It validates and clamps the rectangle, then drives the writer's x1/y1/width/height/color/enable/ack/reset inputs through its level handshake.
- It reports completion or error to the control FSM.

Parameters:
- BYTES_PER_PIXEL, params::BYTES_PER_PIXEL, number of color bytes per pixel.
- PIXEL_HEIGHT, params::PIXEL_HEIGHT, panel rows.
- PIXEL_WIDTH, params::PIXEL_WIDTH, panel columns.
- TIMEOUT_CYCLES, PIXEL_WIDTH*PIXEL_HEIGHT*BYTES_PER_PIXEL+16, maximum RUN cycles before abort.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle pulse; fillarea opcode accepted.
- abort  in  1  level; cancel the current command.
- data_in  in  8  argument byte.
- data_valid  in  1  one-cycle strobe qualifying data_in.
- x1  out  XW  clamped start column. XW = calc::num_column_address_bits(PIXEL_WIDTH).
- y1  out  YW  clamped start row. YW = calc::num_row_address_bits(PIXEL_HEIGHT).
- width  out  XW  clamped width.
- height  out  YW  clamped height.
- color  out  BYTES_PER_PIXEL*8  color, first received byte in the MSBs.
- sub_enable  out  1  enable to the writer.
- sub_ack  out  1  ack to the writer.
- sub_reset  out  1  synchronous reset pulse to the writer.
- sub_done  in  1  done from the writer.
- busy  out  1  high in every state except IDLE.
- cmd_done  out  1  one-cycle completion pulse.
- cmd_error  out  1  sticky; cleared on the next cmd_start.

Behaviour:
- Reset values: all outputs 0, state IDLE, watchdog and byte counters 0.
- Argument byte counts:
  - Each coordinate field is ceil(width/8) bytes, sent MSB byte first.
  - Bytes are shifted into the field register; upper bits beyond XW/YW are discarded.
- States: IDLE, ARG_X1, ARG_Y1, ARG_W, ARG_H, ARG_COLOR, CHECK, RUN, DRAIN, ACK, FINISH.
- IDLE: cmd_start -> ARG_X1 and cmd_error cleared. data_valid is ignored in IDLE.
- ARG_* states:
  - Each data_valid consumes one byte.
  - The state advances when its byte count completes.
  - ARG_COLOR needs BYTES_PER_PIXEL bytes.
- CHECK (1 cycle), evaluated in order with XW+1 / YW+1 bit arithmetic:
  - x1>=PIXEL_WIDTH or y1>=PIXEL_HEIGHT -> set cmd_error, go to FINISH.
  - width==0 or height==0 -> go to FINISH with no error and no writes.
  - x1+width>PIXEL_WIDTH -> width=PIXEL_WIDTH-x1. Same rule applies to height.
  - Otherwise -> RUN.
  - x2 wrapping to 0 when x1+width==PIXEL_WIDTH (power-of-two width) is legal.
- RUN:
  - sub_enable=1 and the watchdog counts.
  - sub_done high -> DRAIN.
  - The writer raises done two enable cycles before its final write completes.
- DRAIN: sub_enable stays 1 for exactly 2 more cycles, then -> ACK.
- ACK:
  - sub_enable=0, sub_ack=1.
  - sub_ack is held until sub_done is sampled low, then sub_ack=0 -> FINISH.
- FINISH: cmd_done pulses for 1 cycle -> IDLE.
- Outputs x1..color are stable from CHECK exit until IDLE. They are not cleared afterwards.
- Watchdog:
  - In RUN, DRAIN or ACK, reaching TIMEOUT_CYCLES -> sub_reset pulse (1 cycle), cmd_error=1, sub_enable=sub_ack=0 -> FINISH.
- abort:
  - In ARG_* or CHECK -> IDLE next cycle; no cmd_done, no writes.
  - In RUN, DRAIN or ACK -> same path as the watchdog (sub_reset, cmd_error, FINISH).
  - abort has priority over data_valid and sub_done in the same cycle.
- cmd_start while busy is ignored.
- reset_n low mid-command: immediate return to the reset values. The writer's reset is driven elsewhere from the same reset.

Decomposition:
- Shared package entries:
  - state enum fillarea_args_fsm_t.
  - localparams X_ARG_BYTES = (XW+7)/8 and Y_ARG_BYTES = (YW+7)/8.
  - TIMEOUT_CYCLES default expression.
- Counter width: calc::num_bits style helper.
- Sub-module: control_arg_shifter. Generic N-byte shift register with a byte counter and a "full" flag; reused for each coordinate field and for color.

Test Plan (64x32, BYTES_PER_PIXEL=2; all writes checked by a scoreboard on the writer outputs):
- Nominal fill. Bytes 04,02,03,02,AB,CD -> 3x2 area at (4,2); 12 writes of AB/CD; one cmd_done; cmd_error=0; sub_ack released after sub_done falls.
- Clamp. x1=62, width=5, height=1 -> width output 2; 4 writes at columns 62..63; no error.
- Reject. x1=64 -> cmd_error=1, cmd_done pulse, sub_enable never asserted. Separately, width=0 -> cmd_done, no error, no writes.
- Abort mid-argument. Abort after 3 bytes -> IDLE next cycle, no cmd_done; the next command then completes normally.
- Watchdog. Stub the writer with sub_done stuck at 0 -> sub_reset pulse after TIMEOUT_CYCLES, cmd_error=1, cmd_done pulse.
- Async reset. reset_n low during RUN -> all outputs 0 without waiting for a clock edge; data_valid during IDLE ignored afterwards.
